// File: rtl/opb_register_bank_ppc2simulink.sv
// OPB slave bank of shadow registers that are committed atomically to user-facing active registers.
// Runs entirely on OPB_Clk; the active outputs feed user logic in the same clock domain.
module opb_register_bank_ppc2simulink #(
    parameter int                      C_OPB_AWIDTH  = 32,
    parameter int                      C_OPB_DWIDTH  = 32,
    parameter logic [C_OPB_AWIDTH-1:0] C_BASEADDR    = 32'h01000300,
    parameter logic [C_OPB_AWIDTH-1:0] C_HIGHADDR    = 32'h010003FF,
    parameter int                      C_NUM_REGS    = 4,
    parameter logic [C_OPB_DWIDTH-1:0] C_RESET_VAL   = '0,
    parameter int                      C_AUTO_COMMIT = 0,
    parameter                          C_FAMILY      = "virtex5"
) (
    input  logic                                 OPB_Clk,
    input  logic                                 OPB_Rst_n,
    input  logic [0:C_OPB_AWIDTH-1]              OPB_ABus,
    input  logic [0:C_OPB_DWIDTH/8-1]            OPB_BE,
    input  logic [0:C_OPB_DWIDTH-1]              OPB_DBus,
    input  logic                                 OPB_RNW,
    input  logic                                 OPB_select,
    input  logic                                 OPB_seqAddr,
    output logic [0:C_OPB_DWIDTH-1]              Sl_DBus,
    output logic                                 Sl_xferAck,
    output logic                                 Sl_errAck,
    output logic                                 Sl_retry,
    output logic                                 Sl_toutSup,
    output logic [C_NUM_REGS*C_OPB_DWIDTH-1:0]   user_data_out,
    output logic                                 user_update
);

    // state | meaning
    // IDLE  | waiting for a select that hits the decoded range
    // ACK   | acknowledge cycle; write/commit performed at its closing edge
    // WAIT  | transfer done, hold until OPB_select drops (one ack per select)
    typedef enum logic [1:0] {IDLE, ACK, WAIT} state_t;

    localparam int DW = C_OPB_DWIDTH;
    localparam int AW = C_OPB_AWIDTH;
    localparam int OW = AW - 2;
    localparam int NB = DW / 8;
    localparam logic [OW-1:0] CTRL_OFS = OW'(C_NUM_REGS);
    localparam bit AUTO = (C_AUTO_COMMIT != 0);

    state_t state, state_nxt;

    logic [AW-1:0] addr, addr_rel;
    logic [DW-1:0] wdata;
    logic [NB-1:0] be;
    logic [OW-1:0] ofs;
    logic          hit;

    logic [DW-1:0] shadow [C_NUM_REGS];
    logic [DW-1:0] active [C_NUM_REGS];
    logic [DW-1:0] merged [C_NUM_REGS];
    logic          pending;
    logic [15:0]   commit_count;

    logic          q_rnw;
    logic [OW-1:0] q_ofs;
    logic [NB-1:0] q_be;
    logic [DW-1:0] q_data;
    logic [DW-1:0] rd_data;
    logic [DW-1:0] rd_mux;
    logic [DW-1:0] status;

    logic                  ack, wr, commit_cmd, any_wr, commit_any;
    logic [C_NUM_REGS-1:0] wr_reg;
    logic                  unused_ok;

    assign addr     = OPB_ABus;
    assign wdata    = OPB_DBus;
    assign be       = OPB_BE;
    assign hit      = OPB_select && (addr >= C_BASEADDR) && (addr <= C_HIGHADDR);
    assign addr_rel = addr - C_BASEADDR;
    assign ofs      = addr_rel[AW-1:2];

    always_comb begin
        status               = '0;
        status[DW-1]         = pending;
        status[15:0]         = commit_count;
    end

    always_comb begin
        rd_mux = '0;
        if (ofs == CTRL_OFS) begin
            rd_mux = status;
        end
        for (int k = 0; k < C_NUM_REGS; k++) begin
            if (ofs == OW'(k)) begin
                rd_mux = shadow[k];
            end
        end
    end

    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (hit) state_nxt = ACK;
            ACK:     state_nxt = WAIT;
            WAIT:    if (!OPB_select) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Read data is captured together with the request so the ack cycle returns a registered value.
    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            q_rnw   <= 1'b0;
            q_ofs   <= '0;
            q_be    <= '0;
            q_data  <= '0;
            rd_data <= '0;
        end else if (state == IDLE && hit) begin
            q_rnw   <= OPB_RNW;
            q_ofs   <= ofs;
            q_be    <= be;
            q_data  <= wdata;
            rd_data <= rd_mux;
        end
    end

    assign ack = (state == ACK);
    assign wr  = ack && !q_rnw;

    always_comb begin
        for (int k = 0; k < C_NUM_REGS; k++) begin
            merged[k] = shadow[k];
            for (int b = 0; b < NB; b++) begin
                if (q_be[b]) begin
                    merged[k][8*b +: 8] = q_data[8*b +: 8];
                end
            end
            wr_reg[k] = wr && (q_ofs == OW'(k));
        end
    end

    assign commit_cmd = wr && (q_ofs == CTRL_OFS) && q_data[0];
    assign any_wr     = |wr_reg;
    assign commit_any = commit_cmd || (AUTO && any_wr);

    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            for (int k = 0; k < C_NUM_REGS; k++) begin
                shadow[k] <= C_RESET_VAL;
                active[k] <= C_RESET_VAL;
            end
            pending      <= 1'b0;
            commit_count <= '0;
            user_update  <= 1'b0;
        end else begin
            user_update <= commit_any;
            if (commit_any) begin
                commit_count <= commit_count + 16'd1;
            end
            if (commit_cmd) begin
                pending <= 1'b0;
            end else if (any_wr && !AUTO) begin
                pending <= 1'b1;
            end
            for (int k = 0; k < C_NUM_REGS; k++) begin
                if (wr_reg[k]) begin
                    shadow[k] <= merged[k];
                end
                // Auto-commit takes the post-write value so the active word never lags its shadow.
                if (commit_cmd) begin
                    active[k] <= shadow[k];
                end else if (AUTO && wr_reg[k]) begin
                    active[k] <= merged[k];
                end
            end
        end
    end

    always_comb begin
        user_data_out = '0;
        for (int k = 0; k < C_NUM_REGS; k++) begin
            user_data_out[k*DW +: DW] = active[k];
        end
    end

    assign Sl_xferAck = ack;
    assign Sl_DBus    = (ack && q_rnw) ? rd_data : '0;
    assign Sl_errAck  = 1'b0;
    assign Sl_retry   = 1'b0;
    assign Sl_toutSup = 1'b0;

    assign unused_ok = ^{OPB_seqAddr, addr_rel[1:0], C_FAMILY};

endmodule

// File: tb/tb_opb_register_bank_ppc2simulink.sv
// Bench for the OPB register bank: one manual-commit and one auto-commit instance on a shared bus.
module tb_opb_register_bank_ppc2simulink;

    localparam logic [31:0] BA = 32'h01000300;
    localparam logic [31:0] BB = 32'h01000400;
    localparam logic [127:0] U_ALL = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    localparam logic [127:0] U_B1  = {32'h0, 32'h12345678, 32'h0, 32'h0};
    localparam logic [127:0] U_B2  = {32'h0, 32'h12345678, 32'h0, 32'h000000EE};

    typedef struct {
        string       name;
        logic [31:0] exp;
    } exp_t;

    typedef struct {
        string        name;
        bit           inst;
        logic [31:0]  addr;
        bit           rnw;
        logic [3:0]   be;
        logic [31:0]  wd;
        logic [31:0]  rd;
        bit           upd;
        logic [127:0] udo;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [0:31] abus = '0;
    logic [0:31] dbus = '0;
    logic [0:3]  be = '0;
    logic        rnw = 1'b0;
    logic        sel = 1'b0;
    logic        seq = 1'b0;

    logic [0:31]  dbus_a, dbus_b;
    logic         ack_a, ack_b, err_a, err_b, retry_a, retry_b, tout_a, tout_b;
    logic [127:0] udo_a, udo_b;
    logic         upd_a, upd_b;
    logic         ack_any;
    logic [31:0]  rd_any;

    int           n_cmp = 0;
    int           n_err = 0;
    int           acks = 0;
    logic [127:0] udo_a_ack = '0;
    logic [127:0] udo_b_ack = '0;
    exp_t         sb[$];

    always #5 clk = ~clk;

    opb_register_bank_ppc2simulink #(
        .C_BASEADDR(BA), .C_HIGHADDR(32'h010003FF), .C_NUM_REGS(4),
        .C_RESET_VAL(32'h0), .C_AUTO_COMMIT(0)
    ) dut_a (
        .OPB_Clk(clk), .OPB_Rst_n(rst_n), .OPB_ABus(abus), .OPB_BE(be), .OPB_DBus(dbus),
        .OPB_RNW(rnw), .OPB_select(sel), .OPB_seqAddr(seq),
        .Sl_DBus(dbus_a), .Sl_xferAck(ack_a), .Sl_errAck(err_a), .Sl_retry(retry_a),
        .Sl_toutSup(tout_a), .user_data_out(udo_a), .user_update(upd_a)
    );

    opb_register_bank_ppc2simulink #(
        .C_BASEADDR(BB), .C_HIGHADDR(32'h010004FF), .C_NUM_REGS(4),
        .C_RESET_VAL(32'h0), .C_AUTO_COMMIT(1)
    ) dut_b (
        .OPB_Clk(clk), .OPB_Rst_n(rst_n), .OPB_ABus(abus), .OPB_BE(be), .OPB_DBus(dbus),
        .OPB_RNW(rnw), .OPB_select(sel), .OPB_seqAddr(seq),
        .Sl_DBus(dbus_b), .Sl_xferAck(ack_b), .Sl_errAck(err_b), .Sl_retry(retry_b),
        .Sl_toutSup(tout_b), .user_data_out(udo_b), .user_update(upd_b)
    );

    assign ack_any = ack_a | ack_b;
    assign rd_any  = dbus_a | dbus_b;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Every ack pops one expectation; write acks must present zero read data.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (ack_any) begin
            acks++;
            udo_a_ack = udo_a;
            udo_b_ack = udo_b;
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_ack: got ack with data %h expected no ack", rd_any);
            end else begin
                e = sb.pop_front();
                check({"rdata ", e.name}, rd_any, e.exp);
            end
        end
    end

    task automatic xfer(input string name, input logic [31:0] a, input bit r,
                        input logic [3:0] b, input logic [31:0] d, input logic [31:0] exp_rd);
        int start;
        @(posedge clk); #1;
        abus = a; rnw = r; be = b; dbus = d; sel = 1'b1;
        sb.push_back('{name, r ? exp_rd : 32'h0});
        start = acks;
        for (int i = 0; i < 8 && acks == start; i++) begin
            @(negedge clk); #1;
        end
        if (acks == start) begin
            n_cmp++;
            n_err++;
            $display("FAIL ack_timeout %s: got no ack expected one", name);
            void'(sb.pop_back());
        end
        @(posedge clk); #1;
        sel = 1'b0; rnw = 1'b0; dbus = '0; be = '0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t         vt[$];
        logic [127:0] prev [2];
        logic [127:0] act_udo, old_udo;
        logic         act_upd;
        int           start;
        logic [31:0]  no_ack_addr [2];

        prev[0] = '0;
        prev[1] = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check("reset_udo_a", udo_a, '0);
        check("reset_udo_b", udo_b, '0);
        check("reset_upd", {upd_a, upd_b}, '0);

        // Dirty the bank, then reset during the ack cycle of a read.
        xfer("pre_w0", BA, 0, 4'hF, 32'h5A5A5A5A, 0);
        xfer("pre_commit", BA + 32'h10, 0, 4'hF, 32'h1, 0);
        check("pre_udo_a", udo_a, {96'h0, 32'h5A5A5A5A});
        xfer("pre_w1", BA + 32'h4, 0, 4'hF, 32'h77, 0);
        @(posedge clk); #1;
        abus = BA; rnw = 1'b1; be = 4'hF; sel = 1'b1;
        sb.push_back('{"rst_rd", 32'h5A5A5A5A});
        start = acks;
        for (int i = 0; i < 8 && acks == start; i++) begin
            @(negedge clk); #1;
        end
        check("rst_rd_acked", 128'(acks - start), 128'd1);
        if (acks == start) void'(sb.pop_back());
        rst_n = 1'b0;
        #1;
        check("rst_ack_low", ack_any, 1'b0);
        check("rst_dbus_zero", rd_any, '0);
        check("rst_udo_a", udo_a, '0);
        sel = 1'b0; rnw = 1'b0; be = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        vt.push_back('{"a_r1_after_rst", 0, BA + 32'h4,  1, 4'hF,    32'h0,        32'h0,        0, 128'h0});
        vt.push_back('{"a_stat_rst",     0, BA + 32'h10, 1, 4'hF,    32'h0,        32'h0,        0, 128'h0});
        vt.push_back('{"a_w1_be1010",    0, BA + 32'h4,  0, 4'b1010, 32'hAABBCCDD, 32'h0,        0, 128'h0});
        vt.push_back('{"a_r1_be",        0, BA + 32'h4,  1, 4'hF,    32'h0,        32'hAA00CC00, 0, 128'h0});
        vt.push_back('{"a_stat_pend",    0, BA + 32'h10, 1, 4'hF,    32'h0,        32'h80000000, 0, 128'h0});
        vt.push_back('{"a_w0",           0, BA + 32'h0,  0, 4'hF,    32'h11111111, 32'h0,        0, 128'h0});
        vt.push_back('{"a_w1",           0, BA + 32'h4,  0, 4'hF,    32'h22222222, 32'h0,        0, 128'h0});
        vt.push_back('{"a_w2",           0, BA + 32'h8,  0, 4'hF,    32'h33333333, 32'h0,        0, 128'h0});
        vt.push_back('{"a_w3",           0, BA + 32'hC,  0, 4'hF,    32'h44444444, 32'h0,        0, 128'h0});
        vt.push_back('{"a_r2",           0, BA + 32'h8,  1, 4'hF,    32'h0,        32'h33333333, 0, 128'h0});
        vt.push_back('{"a_commit",       0, BA + 32'h10, 0, 4'hF,    32'h1,        32'h0,        1, U_ALL});
        vt.push_back('{"a_stat_1",       0, BA + 32'h10, 1, 4'hF,    32'h0,        32'h00000001, 0, U_ALL});
        vt.push_back('{"a_r_ofs7",       0, BA + 32'h1C, 1, 4'hF,    32'h0,        32'h0,        0, U_ALL});
        vt.push_back('{"a_r_last",       0, BA + 32'hFC, 1, 4'hF,    32'h0,        32'h0,        0, U_ALL});
        vt.push_back('{"a_w_ofs7",       0, BA + 32'h1C, 0, 4'hF,    32'hFFFFFFFF, 32'h0,        0, U_ALL});
        vt.push_back('{"a_ctrl_nocmt",   0, BA + 32'h10, 0, 4'hF,    32'hFFFFFFFE, 32'h0,        0, U_ALL});
        vt.push_back('{"a_stat_still1",  0, BA + 32'h10, 1, 4'hF,    32'h0,        32'h00000001, 0, U_ALL});
        vt.push_back('{"a_commit_idle",  0, BA + 32'h10, 0, 4'hF,    32'h1,        32'h0,        1, U_ALL});
        vt.push_back('{"a_stat_2",       0, BA + 32'h10, 1, 4'hF,    32'h0,        32'h00000002, 0, U_ALL});
        vt.push_back('{"b_w2_auto",      1, BB + 32'h8,  0, 4'hF,    32'h12345678, 32'h0,        1, U_B1});
        vt.push_back('{"b_stat_1",       1, BB + 32'h10, 1, 4'hF,    32'h0,        32'h00000001, 0, U_B1});
        vt.push_back('{"b_r2",           1, BB + 32'h8,  1, 4'hF,    32'h0,        32'h12345678, 0, U_B1});
        vt.push_back('{"b_w0_be0001",    1, BB + 32'h0,  0, 4'b0001, 32'h000000EE, 32'h0,        1, U_B2});
        vt.push_back('{"b_stat_2",       1, BB + 32'h10, 1, 4'hF,    32'h0,        32'h00000002, 0, U_B2});

        foreach (vt[i]) begin
            xfer(vt[i].name, vt[i].addr, vt[i].rnw, vt[i].be, vt[i].wd, vt[i].rd);
            act_udo = vt[i].inst ? udo_b : udo_a;
            act_upd = vt[i].inst ? upd_b : upd_a;
            check({"udo ", vt[i].name}, act_udo, vt[i].udo);
            check({"upd ", vt[i].name}, act_upd, vt[i].upd);
            if (vt[i].upd) begin
                old_udo = vt[i].inst ? udo_b_ack : udo_a_ack;
                check({"udo_in_ack ", vt[i].name}, old_udo, prev[vt[i].inst]);
                @(posedge clk); #1;
                act_upd = vt[i].inst ? upd_b : upd_a;
                check({"upd_single ", vt[i].name}, act_upd, 1'b0);
            end
            prev[vt[i].inst] = vt[i].udo;
        end

        // Select held for six cycles must produce exactly one ack.
        @(posedge clk); #1;
        abus = BA + 32'h8; rnw = 1'b1; be = 4'hF; sel = 1'b1;
        sb.push_back('{"hold_rd", 32'h33333333});
        start = acks;
        repeat (6) @(negedge clk);
        #1;
        check("hold_one_ack", 128'(acks - start), 128'd1);
        sel = 1'b0; rnw = 1'b0;

        no_ack_addr[0] = 32'h010002FC;
        no_ack_addr[1] = 32'h01000500;
        for (int j = 0; j < 2; j++) begin
            @(posedge clk); #1;
            abus = no_ack_addr[j]; rnw = 1'b1; be = 4'hF; sel = 1'b1;
            start = acks;
            repeat (6) @(negedge clk);
            #1;
            check("outside_no_ack", 128'(acks - start), 128'd0);
            sel = 1'b0; rnw = 1'b0;
        end

        // Preload the counter near the top to exercise the 16-bit wrap in two commits.
        @(posedge clk); #1;
        force dut_a.commit_count = 16'hFFFE;
        #2;
        release dut_a.commit_count;
        for (int j = 0; j < 2; j++) begin
            xfer("wrap_commit", BA + 32'h10, 0, 4'hF, 32'h1, 0);
            check("wrap_upd", upd_a, 1'b1);
            xfer("wrap_stat", BA + 32'h10, 1, 4'hF, 32'h0, (j == 0) ? 32'h0000FFFF : 32'h00000000);
        end

        repeat (2) @(posedge clk);
        #1;
        check("const_zero", {err_a, retry_a, tout_a, err_b, retry_b, tout_b}, '0);
        check("sb_drained", 128'(sb.size()), 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/opb_register_bank_ppc2simulink.md
# opb_register_bank_ppc2simulink

Parametrised OPB slave register bank: the multi-word, atomically-updated successor of the single PPC-to-Simulink software register. The PowerPC writes C_NUM_REGS shadow words over OPB; a commit command (or per-write auto-commit) copies them to the active outputs. The active outputs drive user logic such as FIR coefficient pairs, so multi-word settings change in a single cycle. User logic runs on OPB_Clk, so there is no clock-domain crossing.

## Interface
Parameters:
- C_BASEADDR, 32'h01000300, first byte address of the bank.
- C_HIGHADDR, 32'h010003FF, last byte address decoded.
- C_OPB_AWIDTH, 32, OPB address width.
- C_OPB_DWIDTH, 32, OPB data width; also the width of each register.
- C_NUM_REGS, 4, number of data registers, 1..16; (C_NUM_REGS+1)*4 must be ≤ C_HIGHADDR-C_BASEADDR+1.
- C_RESET_VAL, 32'h0, reset value of every shadow and active register.
- C_AUTO_COMMIT, 0, 1 = each data-register write also commits that register immediately.
- C_FAMILY, "virtex5", target family string, informational only.

Ports:
- OPB_Clk  in  1  sole clock, rising edge.
- OPB_Rst_n  in  1  asynchronous, active-low reset.
- OPB_ABus  in  [0:31]  address.
- OPB_BE  in  [0:3]  byte enables; BE[0] covers DBus[0:7].
- OPB_DBus  in  [0:31]  write data.
- OPB_RNW  in  1  1 = read.
- OPB_select  in  1  transfer request.
- OPB_seqAddr  in  1  ignored.
- Sl_DBus  out  [0:31]  read data; zero except in the ack cycle of a read.
- Sl_xferAck  out  1  one-cycle transfer acknowledge.
- Sl_errAck, Sl_retry, Sl_toutSup  out  1 each  constant 0.
- user_data_out  out  [C_NUM_REGS*32-1:0]  active registers; register k occupies bits [32k+31:32k], OPB bit 0 maps to bit 31.
- user_update  out  1  one-cycle pulse, coincident with any change of user_data_out caused by a commit.

## Operation
- Hit condition: OPB_select=1 and C_BASEADDR ≤ OPB_ABus ≤ C_HIGHADDR. Word offset = (ABus-C_BASEADDR)>>2.
- Offsets 0..C_NUM_REGS-1 are shadow registers. Reads return the shadow value. Writes update only the bytes whose BE bit is 1.
- Offset C_NUM_REGS is CTRL/STATUS.
  - Write with DBus[31] (LSB) = 1: commit, i.e. all actives take the shadow values; other bits are ignored.
  - Read: bit 31 (MSB, OPB bit 0) = pending; bits 15:0 = commit_count; all other bits 0.
- Offsets above C_NUM_REGS read 0 and ignore writes, but are still acknowledged.
- pending: set by any shadow write when C_AUTO_COMMIT=0; cleared by commit. It is always 0 when C_AUTO_COMMIT=1.
- commit_count: 16-bit count that increments on every commit, including auto-commits, and wraps 0xFFFF→0x0000.
- Auto-commit: a shadow write to register k commits only active[k], using the post-write shadow value. The CTRL commit command remains functional in this mode.
- A commit with no pending change still pulses user_update and increments commit_count.
- Control FSM has three states:
  - IDLE → ACK on a hit.
  - ACK (Sl_xferAck=1, write/read performed) → WAIT.
  - WAIT holds until OPB_select=0, then → IDLE. This guarantees exactly one ack per select assertion.
- Reset, asynchronous, effective mid-transfer:
  - FSM goes to IDLE; Sl_xferAck=0, Sl_DBus=0.
  - Shadows and actives = C_RESET_VAL; pending=0; commit_count=0; user_update=0.
  - No partial write is retained.

## Timing
- Cycle T: first rising edge with a hit sampled. Cycle T+1: Sl_xferAck=1 for exactly one cycle. For reads, Sl_DBus is valid in this same cycle and is registered from the value sampled at T.
- Shadow write and pending set take effect at the end of cycle T+1. A shadow read in T+2 returns the new value.
- Commit from a CTRL write at T: actives and user_data_out change at T+2, user_update=1 in T+2 only, and commit_count increments at T+2.
- Auto-commit: same T+2 timing as an explicit commit.
- Back-to-back transfers: the next ack arrives no earlier than 2 cycles after OPB_select deasserts.

## Test plan
- Reset: assert OPB_Rst_n=0 mid-read → Sl_xferAck=0 immediately; after release, every user_data_out word = C_RESET_VAL and STATUS reads 0x00000000.
- Byte enables: write 0xAABBCCDD to reg 1 with BE=1010, starting from reset value 0 → reg 1 reads 0xAA00CC00, user_data_out unchanged, STATUS pending bit = 1.
- Atomic commit (C_NUM_REGS=4): write regs 0..3 with 0x11111111..0x44444444, then write CTRL=1 → all four words change in the same cycle at T+2, user_update is a single pulse, STATUS = 0x00000001.
- Auto-commit=1: write 0x12345678 to reg 2 → only word 2 changes at T+2, pending stays 0, commit_count = 1.
- Protocol: hold OPB_select high for 6 cycles on a read → exactly one Sl_xferAck pulse; an out-of-range offset (C_NUM_REGS+3) reads 0 and is acked. An address outside C_BASEADDR..C_HIGHADDR gets no ack.
- Wrap: issue 65536 commits → commit_count reads 0x0000 and user_update pulses every time.
